dmem_responder: RTL and testbench

- Data-memory responder for the pipeline's MEM stage: answers load/store requests (byte, half, word; signed/unsigned) from the core side.
- Owns a word-organised little-endian RAM with byte-lane writes and load-data sign/zero extension.
- Uses a valid/ready request handshake, a programmable wait-state counter and a single-cycle response pulse.
- Serves as the memory end that load/store test programs exercise.

---
 rtl/dmem_responder.sv | 252 +++++++++++++++++++++++++
 tb/tb_dmem_responder.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
//============================================================================
// Module      : dmem_responder
// Description : MEM-stage data-memory responder. Word-organised little-endian
//               RAM with byte-lane stores, sign/zero-extended loads, a
//               valid/ready request handshake, WAIT_STATES programmable
//               latency and a one-cycle response pulse.
//               Optional macro DMEM_STATS_EN adds saturating load/store/error
//               response counters.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module dmem_responder #(
    parameter int ADDR_WIDTH  = 8,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error
`ifdef DMEM_STATS_EN
    ,
    output logic [15:0] load_count,
    output logic [15:0] store_count,
    output logic [15:0] error_count
`endif
);

    localparam int         c_depth     = 1 << ADDR_WIDTH;
    localparam logic [3:0] c_wait_init = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        write_q, write_d;
    logic [1:0]  size_q, size_d;
    logic        unsigned_q, unsigned_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        resp_error_q, resp_error_d;

    logic        accept;
    logic        go_resp;
    logic        eff_write;
    logic [1:0]  eff_size;
    logic        eff_unsigned;
    logic [31:0] eff_addr;
    logic [31:0] eff_wdata;
    logic        req_err;
    logic [ADDR_WIDTH-1:0] word_idx;
    logic [31:0] rd_word;
    logic [31:0] wr_word;
    logic [31:0] wr_rep;
    logic [3:0]  wr_be;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;
    logic        mem_we;

    logic [31:0] mem [c_depth];

    assign req_ready = (state_q == S_IDLE) && !reset;
    assign accept    = req_valid && req_ready;

    // With WAIT_STATES=0 the RAM access happens on the accept edge itself,
    // so the live request is used in IDLE and the captured one afterwards.
    assign eff_write    = (state_q == S_IDLE) ? req_write    : write_q;
    assign eff_size     = (state_q == S_IDLE) ? req_size     : size_q;
    assign eff_unsigned = (state_q == S_IDLE) ? req_unsigned : unsigned_q;
    assign eff_addr     = (state_q == S_IDLE) ? req_addr     : addr_q;
    assign eff_wdata    = (state_q == S_IDLE) ? req_wdata    : wdata_q;

    assign req_err = (eff_size == 2'b11)
                   || ((eff_size == 2'b01) && eff_addr[0])
                   || ((eff_size == 2'b10) && (eff_addr[1:0] != 2'b00))
                   || ((eff_addr >> (ADDR_WIDTH + 2)) != 32'd0);

    assign word_idx = eff_addr[ADDR_WIDTH+1:2];
    assign rd_word  = mem[word_idx];
    assign mem_we   = go_resp && eff_write && !req_err && !reset;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        go_resp    = 1'b0;
        write_d    = write_q;
        size_d     = size_q;
        unsigned_d = unsigned_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    write_d    = req_write;
                    size_d     = req_size;
                    unsigned_d = req_unsigned;
                    addr_d     = req_addr;
                    wdata_d    = req_wdata;
                    if (WAIT_STATES > 0) begin
                        state_d = S_WAIT;
                        cnt_d   = c_wait_init;
                    end else begin
                        state_d = S_RESP;
                        go_resp = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_RESP;
                    go_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        wr_be   = 4'b0000;
        wr_rep  = eff_wdata;
        wr_word = rd_word;
        case (eff_size)
            2'b00: begin
                wr_be  = 4'b0001 << eff_addr[1:0];
                wr_rep = {4{eff_wdata[7:0]}};
            end
            2'b01: begin
                wr_be  = eff_addr[1] ? 4'b1100 : 4'b0011;
                wr_rep = {2{eff_wdata[15:0]}};
            end
            2'b10:   wr_be = 4'b1111;
            default: wr_be = 4'b0000;
        endcase
        for (int i = 0; i < 4; i++) begin
            if (wr_be[i]) wr_word[8*i +: 8] = wr_rep[8*i +: 8];
        end
    end

    assign ld_byte = rd_word[{eff_addr[1:0], 3'b000} +: 8];
    assign ld_half = eff_addr[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        case (eff_size)
            2'b00:   ld_data = {{24{!eff_unsigned && ld_byte[7]}}, ld_byte};
            2'b01:   ld_data = {{16{!eff_unsigned && ld_half[15]}}, ld_half};
            default: ld_data = rd_word;
        endcase
    end

    always_comb begin
        resp_valid_d = go_resp;
        resp_rdata_d = resp_rdata_q;
        resp_error_d = resp_error_q;
        if (go_resp) begin
            resp_error_d = req_err;
            resp_rdata_d = (req_err || eff_write) ? 32'd0 : ld_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= 4'd0;
            write_q      <= 1'b0;
            size_q       <= 2'b00;
            unsigned_q   <= 1'b0;
            addr_q       <= 32'd0;
            wdata_q      <= 32'd0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'd0;
            resp_error_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            write_q      <= write_d;
            size_q       <= size_d;
            unsigned_q   <= unsigned_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_error_q <= resp_error_d;
        end
    end

    // RAM contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) mem[word_idx] <= wr_word;
    end

    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_error = resp_error_q;

`ifdef DMEM_STATS_EN
    logic [15:0] load_count_q, load_count_d;
    logic [15:0] store_count_q, store_count_d;
    logic [15:0] error_count_q, error_count_d;

    always_comb begin
        load_count_d  = load_count_q;
        store_count_d = store_count_q;
        error_count_d = error_count_q;
        if (state_q == S_RESP) begin
            if (resp_error_q) begin
                if (error_count_q != 16'hFFFF) error_count_d = error_count_q + 16'd1;
            end else if (write_q) begin
                if (store_count_q != 16'hFFFF) store_count_d = store_count_q + 16'd1;
            end else begin
                if (load_count_q != 16'hFFFF) load_count_d = load_count_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            load_count_q  <= 16'd0;
            store_count_q <= 16'd0;
            error_count_q <= 16'd0;
        end else begin
            load_count_q  <= load_count_d;
            store_count_q <= store_count_d;
            error_count_q <= error_count_d;
        end
    end

    assign load_count  = load_count_q;
    assign store_count = store_count_q;
    assign error_count = error_count_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_dmem_responder.sv
//============================================================================
// Module      : tb_dmem_responder
// Description : Scoreboard bench for dmem_responder (byte-array reference
//               model, directed plus random traffic, WAIT_STATES 3 and 0).
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_dmem_responder;

    localparam int MAIN_WS = 3;
    localparam int AW      = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, req_valid, req_ready, req_write, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata, resp_rdata;
    logic        resp_valid, resp_error;

    logic        rst0, v0, ready0, w0, u0, rv0, re0;
    logic [1:0]  sz0;
    logic [31:0] a0, wd0, rd0;

`ifdef DMEM_STATS_EN
    logic [15:0] lc, sc, ec, lc0, sc0, ec0;
`endif

    dmem_responder #(.ADDR_WIDTH(AW), .WAIT_STATES(MAIN_WS)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
        .resp_rdata(resp_rdata), .resp_error(resp_error)
`ifdef DMEM_STATS_EN
        , .load_count(lc), .store_count(sc), .error_count(ec)
`endif
    );

    dmem_responder #(.ADDR_WIDTH(AW), .WAIT_STATES(0)) dut0 (
        .clk(clk), .reset(rst0), .req_valid(v0), .req_ready(ready0),
        .req_write(w0), .req_size(sz0), .req_unsigned(u0),
        .req_addr(a0), .req_wdata(wd0), .resp_valid(rv0),
        .resp_rdata(rd0), .resp_error(re0)
`ifdef DMEM_STATS_EN
        , .load_count(lc0), .store_count(sc0), .error_count(ec0)
`endif
    );

    typedef struct {
        logic [31:0] rd;
        logic        err;
        logic        wr;
        int          acc;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] bmem [1024];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         prev_acc = 0;
    bit         held = 1'b0;
    int         n_ld = 0, n_st = 0, n_er = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Byte-addressed view of memory: the RAM is just 4<<AW bytes, little-endian.
    task automatic model(input logic w, input logic [1:0] sz, input logic u,
                         input logic [31:0] a, input logic [31:0] wd,
                         output logic [31:0] rd, output logic err);
        int     nb;
        longint v;
        nb  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        err = (sz == 2'd3) || ((a % nb) != 0) || (a >= 32'(4 << AW));
        rd  = 32'd0;
        v   = 0;
        if (!err) begin
            for (int i = 0; i < nb; i++) begin
                if (w) bmem[a + i] = wd[8*i +: 8];
                else   v = v | (longint'(bmem[a + i]) << (8 * i));
            end
            if (!w && !u && nb < 4 && bmem[a + nb - 1][7])
                v = v - (longint'(1) << (8 * nb));
            rd = v[31:0];
        end
    endtask

    // Monitor: checks handshake every cycle and pops the scoreboard on each pulse.
    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            chk("reset_resp_valid", {31'd0, resp_valid}, 32'd0);
            chk("reset_req_ready", {31'd0, req_ready}, 32'd0);
        end else if (resp_valid) begin
            chk("ready_in_resp", {31'd0, req_ready}, 32'd0);
            if (exp_q.size() == 0) begin
                chk("unexpected_resp", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("rdata", resp_rdata, e.rd);
                chk("error", {31'd0, resp_error}, {31'd0, e.err});
                chk("latency", 32'(cyc - e.acc), 32'(MAIN_WS + 1));
                if (e.err) n_er++;
                else if (e.wr) n_st++;
                else n_ld++;
            end
        end else if (cyc > 1) begin
            chk("req_ready", {31'd0, req_ready}, {31'd0, exp_q.size() == 0});
        end
    end

    // Called just after a rising edge; returns just after a rising edge.
    task automatic issue(input logic w, input logic [1:0] sz, input logic u,
                         input logic [31:0] a, input logic [31:0] wd, input int gap);
        logic [31:0] erd;
        logic        eerr;
        exp_t        e;
        int          t;
        req_write = w; req_size = sz; req_unsigned = u; req_addr = a; req_wdata = wd;
        req_valid = 1'b1;
        t = 0;
        @(negedge clk);
        while (!req_ready && t < 60) begin
            @(negedge clk);
            t++;
        end
        if (!req_ready) begin
            chk("accept_timeout", 32'd1, 32'd0);
            @(posedge clk);
            #1 req_valid = 1'b0;
            held = 1'b0;
            return;
        end
        @(posedge clk);
        if (held) chk("b2b_period", 32'(cyc - prev_acc), 32'(MAIN_WS + 2));
        prev_acc = cyc;
        model(w, sz, u, a, wd, erd, eerr);
        e.rd = erd; e.err = eerr; e.wr = w; e.acc = cyc;
        exp_q.push_back(e);
        #1;
        held = (gap == 0);
        if (gap > 0) begin
            req_valid = 1'b0;
            repeat (gap) @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 100) begin
            @(posedge clk);
            t++;
        end
        if (exp_q.size() != 0) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
        held = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t;
        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
        rst0 = 1'b1; v0 = 1'b0; w0 = 1'b0; u0 = 1'b0; sz0 = 2'b00; a0 = 32'd0; wd0 = 32'd0;
        for (int i = 0; i < 1024; i++) bmem[i] = 8'h00;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Byte, half and lane-merge cases (write, size, unsigned, addr, wdata, gap)
        issue(1, 2'b00, 0, 32'h00, 32'h000000FF, 0);
        issue(0, 2'b00, 0, 32'h00, 32'h0, 0);
        issue(0, 2'b00, 1, 32'h00, 32'h0, 1);
        issue(1, 2'b00, 0, 32'h00, 32'h000000FE, 0);
        issue(0, 2'b00, 0, 32'h00, 32'h0, 0);
        issue(0, 2'b00, 1, 32'h00, 32'h0, 2);
        issue(1, 2'b01, 0, 32'h04, 32'h00001234, 0);
        issue(0, 2'b01, 0, 32'h04, 32'h0, 0);
        issue(1, 2'b01, 0, 32'h06, 32'h0000CFC7, 0);
        issue(0, 2'b01, 0, 32'h06, 32'h0, 0);
        issue(0, 2'b01, 1, 32'h06, 32'h0, 0);
        issue(0, 2'b10, 0, 32'h04, 32'h0, 1);
        issue(1, 2'b10, 0, 32'h0C, 32'hAABBCCDD, 0);
        issue(1, 2'b00, 0, 32'h0D, 32'h00000012, 0);
        issue(0, 2'b10, 0, 32'h0C, 32'h0, 1);
        issue(1, 2'b10, 0, 32'h08, 32'hFFFFFFFF, 0);
        issue(0, 2'b10, 1, 32'h08, 32'h0, 1);
        // Errors, then confirm the aliased word 0 was not touched
        issue(0, 2'b01, 0, 32'h05, 32'h0, 0);
        issue(0, 2'b10, 0, 32'h0A, 32'h0, 0);
        issue(0, 2'b11, 0, 32'h00, 32'h0, 0);
        issue(1, 2'b10, 0, 32'h400, 32'h12345678, 0);
        issue(0, 2'b10, 0, 32'h00, 32'h0, 1);
        drain();

        // Reset while a store sits in WAIT: no pulse, store dropped
        req_write = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
        req_addr = 32'h10; req_wdata = 32'h55; req_valid = 1'b1;
        t = 0;
        @(negedge clk);
        while (!req_ready && t < 60) begin
            @(negedge clk);
            t++;
        end
        if (!req_ready) chk("abort_accept_timeout", 32'd1, 32'd0);
        @(posedge clk);
        #1 req_valid = 1'b0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_rdata", resp_rdata, 32'd0);
        chk("reset_error", {31'd0, resp_error}, 32'd0);
        n_ld = 0; n_st = 0; n_er = 0;
        @(posedge clk);
        #1 reset = 1'b0;
        issue(0, 2'b10, 0, 32'h10, 32'h0, 1);
        drain();

        // Randomised traffic: mostly aligned, some misaligned, illegal or out of range
        for (int n = 0; n < 150; n++) begin
            logic        w, u;
            logic [1:0]  sz;
            logic [31:0] a;
            int          r;
            w  = 1'($urandom_range(0, 1));
            u  = 1'($urandom_range(0, 1));
            r  = $urandom_range(0, 19);
            sz = (r == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            a  = 32'($urandom_range(0, 63));
            if (r > 2) a = a & ~((32'd1 << sz) - 32'd1);
            if (r == 1) a = a | (32'h400 << $urandom_range(0, 21));
            issue(w, sz, u, a, $urandom, $urandom_range(0, 2));
        end
        drain();

`ifdef DMEM_STATS_EN
        chk("load_count", {16'd0, lc}, 32'(n_ld));
        chk("store_count", {16'd0, sc}, 32'(n_st));
        chk("error_count", {16'd0, ec}, 32'(n_er));
`endif

        // Zero-wait instance: SW then a held LB gives pulses every 2 cycles
        @(posedge clk);
        #1 rst0 = 1'b0;
        v0 = 1'b1; w0 = 1'b1; sz0 = 2'b10; u0 = 1'b0; a0 = 32'h20; wd0 = 32'h8899AABB;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("ws0_resp_valid", {31'd0, rv0}, {31'd0, (k % 2) == 1});
            chk("ws0_req_ready", {31'd0, ready0}, {31'd0, (k % 2) == 0});
            if ((k % 2) == 1) begin
                chk("ws0_rdata", rd0, (k == 1) ? 32'd0 : 32'hFFFFFFAA);
                chk("ws0_error", {31'd0, re0}, 32'd0);
            end
            if (k == 0) begin
                @(posedge clk);
                #1 w0 = 1'b0; sz0 = 2'b00; a0 = 32'h21;
            end
        end
        v0 = 1'b0;
        repeat (2) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
